// File: rtl/core_dispatcher_if.sv
// ---------------------------------------------------------------------------
// core_dispatcher_if
//   Bundles the dispatcher's work-input, per-core dispatch/result, drained
//   output and status signals so the dispatcher and its environment connect
//   through a single port.
//
//   Signal groups:
//     work input   : in_data, in_valid, in_ready, pred_hint, pred_hint_valid
//     core side    : core_data, core_valid, core_result, core_result_valid
//     drain output : out_data, out_tag, out_valid, out_ready
//     status       : busy_count, err_spurious
//
//   Modports:
//     slave  - the dispatcher itself
//     master - the surrounding array / stream environment
// ---------------------------------------------------------------------------
interface core_dispatcher_if #(
  parameter int NUM_CORES = 8,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 3
);

  logic [DATA_W-1:0]           in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [TAG_W-1:0]            pred_hint;
  logic                        pred_hint_valid;

  logic [NUM_CORES*DATA_W-1:0] core_data;
  logic [NUM_CORES-1:0]        core_valid;
  logic [NUM_CORES*DATA_W-1:0] core_result;
  logic [NUM_CORES-1:0]        core_result_valid;

  logic [DATA_W-1:0]           out_data;
  logic [TAG_W-1:0]            out_tag;
  logic                        out_valid;
  logic                        out_ready;

  logic [TAG_W:0]              busy_count;
  logic                        err_spurious;

  modport slave (
    input  in_data, in_valid, pred_hint, pred_hint_valid,
    input  core_result, core_result_valid, out_ready,
    output in_ready, core_data, core_valid,
    output out_data, out_tag, out_valid, busy_count, err_spurious
  );

  modport master (
    output in_data, in_valid, pred_hint, pred_hint_valid,
    output core_result, core_result_valid, out_ready,
    input  in_ready, core_data, core_valid,
    input  out_data, out_tag, out_valid, busy_count, err_spurious
  );

endinterface

// File: rtl/core_dispatcher.sv
// ---------------------------------------------------------------------------
// core_dispatcher
//   Work scheduler for the logic cores of the core array. Accepts work words
//   over a valid/ready handshake, sends each word to an idle core (steered by
//   the prediction-core hint when that core is idle, otherwise round-robin),
//   buffers one result per core and drains buffered results round-robin onto
//   a single tagged output stream.
//
//   Ports:
//     clk    - single clock, rising edge
//     reset  - synchronous, active-high
//     bus    - core_dispatcher_if.slave: work input, per-core dispatch and
//              result buses, drained output stream, busy_count, err_spurious
// ---------------------------------------------------------------------------
module core_dispatcher #(
  parameter int NUM_CORES = 8,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 3
) (
  input  logic         clk,
  input  logic         reset,
  core_dispatcher_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } core_state_e;

  core_state_e                 state_q [NUM_CORES];
  core_state_e                 state_d [NUM_CORES];
  logic [DATA_W-1:0]           res_q   [NUM_CORES];
  logic [DATA_W-1:0]           res_d   [NUM_CORES];

  logic [TAG_W-1:0]            disp_ptr_q, disp_ptr_d;
  logic [TAG_W-1:0]            out_ptr_q,  out_ptr_d;
  logic [NUM_CORES-1:0]        core_valid_q, core_valid_d;
  logic [NUM_CORES*DATA_W-1:0] core_data_q,  core_data_d;
  logic                        out_valid_q, out_valid_d;
  logic [DATA_W-1:0]           out_data_q,  out_data_d;
  logic [TAG_W-1:0]            out_tag_q,   out_tag_d;
  logic [TAG_W:0]              busy_count_q, busy_count_d;
  logic                        err_q, err_d;

  logic                        any_idle, any_done;
  logic [TAG_W-1:0]            rr_idle_idx, done_idx, disp_tgt;
  logic                        in_ready, dispatch, out_free, load_out;

  // Round-robin scans: first IDLE core at or above disp_ptr, first DONE core
  // at or above out_ptr. TAG_W-bit index arithmetic gives the wrap for free.
  always_comb begin
    // NOTE: every combinationally driven signal gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latches).
    any_idle    = 1'b0;
    rr_idle_idx = '0;
    any_done    = 1'b0;
    done_idx    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!any_idle && state_q[disp_ptr_q + TAG_W'(k)] == IDLE) begin
        any_idle    = 1'b1;
        rr_idle_idx = disp_ptr_q + TAG_W'(k);
      end
      if (!any_done && state_q[out_ptr_q + TAG_W'(k)] == DONE) begin
        any_done = 1'b1;
        done_idx = out_ptr_q + TAG_W'(k);
      end
    end
  end

  assign in_ready = any_idle && !reset;
  assign dispatch = bus.in_valid && in_ready;
  assign disp_tgt = (bus.pred_hint_valid && state_q[bus.pred_hint] == IDLE)
                    ? bus.pred_hint : rr_idle_idx;
  assign out_free = !out_valid_q || bus.out_ready;
  assign load_out = out_free && any_done;

  // Next-state: dispatch, result capture and output load may all happen in
  // one cycle; they never touch the same core because each requires a
  // different registered state (IDLE, BUSY, DONE respectively).
  always_comb begin
    state_d       = state_q;
    res_d         = res_q;
    disp_ptr_d    = disp_ptr_q;
    out_ptr_d     = out_ptr_q;
    core_valid_d  = '0;
    core_data_d   = core_data_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_tag_d     = out_tag_q;
    err_d         = err_q;
    busy_count_d  = '0;

    if (dispatch) begin
      state_d[disp_tgt]                               = BUSY;
      core_valid_d[disp_tgt]                          = 1'b1;
      core_data_d[int'(disp_tgt)*DATA_W +: DATA_W]    = bus.in_data;
      disp_ptr_d                                      = disp_tgt + TAG_W'(1);
    end

    for (int i = 0; i < NUM_CORES; i++) begin
      if (bus.core_result_valid[i]) begin
        if (state_q[i] == BUSY) begin
          state_d[i] = DONE;
          res_d[i]   = bus.core_result[i*DATA_W +: DATA_W];
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (load_out) begin
      state_d[done_idx] = IDLE;
      out_valid_d       = 1'b1;
      out_data_d        = res_q[done_idx];
      out_tag_d         = done_idx;
      out_ptr_d         = done_idx + TAG_W'(1);
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end

    for (int i = 0; i < NUM_CORES; i++) begin
      if (state_d[i] != IDLE) busy_count_d = busy_count_d + (TAG_W+1)'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of all others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= '{default: IDLE};
      disp_ptr_q   <= '0;
      out_ptr_q    <= '0;
      core_valid_q <= '0;
      core_data_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_tag_q    <= '0;
      busy_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      disp_ptr_q   <= disp_ptr_d;
      out_ptr_q    <= out_ptr_d;
      core_valid_q <= core_valid_d;
      core_data_q  <= core_data_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      busy_count_q <= busy_count_d;
      err_q        <= err_d;
    end
  end

  // NOTE: the per-core result buffers carry no reset; a buffer is only read
  // when its core is DONE, and reset forces every core IDLE, which discards
  // whatever the buffers hold.
  always_ff @(posedge clk) begin
    res_q <= res_d;
  end

  assign bus.in_ready     = in_ready;
  assign bus.core_valid   = core_valid_q;
  assign bus.core_data    = core_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_tag      = out_tag_q;
  assign bus.busy_count   = busy_count_q;
  assign bus.err_spurious = err_q;

endmodule

// File: tb/tb_core_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_core_dispatcher
//   Directed bench for core_dispatcher. Stimulus pushes expected dispatches
//   (core, word) and expected drained outputs (tag, word) into queues; a
//   monitor on the falling edge pops and compares whenever the DUT strobes a
//   core or hands over an output word. Status signals are checked directly
//   from the stimulus process.
// ---------------------------------------------------------------------------
module tb_core_dispatcher;

  localparam int NC = 8;
  localparam int DW = 32;
  localparam int TW = 3;

  typedef struct {
    int          core;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;

  core_dispatcher_if #(.NUM_CORES(NC), .DATA_W(DW), .TAG_W(TW)) bus ();

  core_dispatcher #(.NUM_CORES(NC), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t disp_q [$];
  exp_t out_q  [$];
  exp_t de, oe;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_disp(input int core, input logic [31:0] data);
    exp_t e;
    e.core = core;
    e.data = data;
    disp_q.push_back(e);
  endtask

  task automatic push_out(input int tag, input logic [31:0] data);
    exp_t e;
    e.core = tag;
    e.data = data;
    out_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] data, input logic hv,
                      input logic [TW-1:0] hint, input int exp_core);
    bus.in_data         = data;
    bus.in_valid        = 1'b1;
    bus.pred_hint       = hint;
    bus.pred_hint_valid = hv;
    push_disp(exp_core, data);
    step();
    bus.in_valid        = 1'b0;
    bus.pred_hint_valid = 1'b0;
  endtask

  task automatic strobe(input int core, input logic [31:0] data);
    bus.core_result[core*DW +: DW] = data;
    bus.core_result_valid[core]    = 1'b1;
  endtask

  // Monitor: sample away from the rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.core_valid != '0) begin
        if (disp_q.size() == 0) begin
          check("disp_unexpected", 64'(bus.core_valid), 64'd0);
        end else begin
          de = disp_q.pop_front();
          check("disp_strobe", 64'(bus.core_valid), 64'(1) << de.core);
          check("disp_data", 64'(bus.core_data[de.core*DW +: DW]), 64'(de.data));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (out_q.size() == 0) begin
          check("out_unexpected", 64'(bus.out_valid), 64'd0);
        end else begin
          oe = out_q.pop_front();
          check("out_tag", 64'(bus.out_tag), 64'(oe.core));
          check("out_data", 64'(bus.out_data), 64'(oe.data));
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    step();
    check("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
    step();
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_busy", 64'(bus.busy_count), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_core_valid", 64'(bus.core_valid), 64'd0);
    check("rst_core_data", 64'(|bus.core_data), 64'd0);
    check("rst_err", 64'(bus.err_spurious), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset                 = 1'b1;
    bus.in_data           = '0;
    bus.in_valid          = 1'b0;
    bus.pred_hint         = '0;
    bus.pred_hint_valid   = 1'b0;
    bus.core_result       = '0;
    bus.core_result_valid = '0;
    bus.out_ready         = 1'b1;
    do_reset();

    // 1: fill all eight cores round-robin.
    for (int i = 0; i < NC; i++) send(32'h100 + 32'(i), 1'b0, '0, i);
    check("fill_in_ready", 64'(bus.in_ready), 64'd0);
    check("fill_busy", 64'(bus.busy_count), 64'd8);

    // 2: core 5 completes; freed core takes the next word.
    strobe(5, 32'hDEAD_0005);
    push_out(5, 32'hDEAD_0005);
    step();
    bus.core_result_valid = '0;
    check("c5_done_busy", 64'(bus.busy_count), 64'd8);
    check("c5_out_valid_early", 64'(bus.out_valid), 64'd0);
    step();
    check("c5_out_valid", 64'(bus.out_valid), 64'd1);
    check("c5_busy", 64'(bus.busy_count), 64'd7);
    check("c5_in_ready", 64'(bus.in_ready), 64'd1);
    send(32'h200, 1'b0, '0, 5);
    step();

    // 3: hinted dispatch, then hint on a busy core falls back to round-robin.
    do_reset();
    send(32'h300, 1'b1, 3'd6, 6);
    send(32'h301, 1'b1, 3'd6, 7);
    send(32'h302, 1'b0, '0, 0);
    send(32'h303, 1'b0, '0, 1);
    send(32'h304, 1'b1, 3'd3, 3);
    send(32'h305, 1'b0, '0, 4);
    check("hint_busy", 64'(bus.busy_count), 64'd6);

    // 4: three simultaneous completions against a stalled consumer.
    bus.out_ready = 1'b0;
    strobe(1, 32'hA1);
    strobe(3, 32'hA3);
    strobe(4, 32'hA4);
    push_out(1, 32'hA1);
    push_out(3, 32'hA3);
    push_out(4, 32'hA4);
    step();
    bus.core_result_valid = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_tag", 64'(bus.out_tag), 64'd1);
      check("stall_data", 64'(bus.out_data), 64'hA1);
      step();
    end
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("drain_idle", 64'(bus.out_valid), 64'd0);
    check("drain_busy", 64'(bus.busy_count), 64'd3);

    // 5: spurious strobe on idle core 2.
    strobe(2, 32'h0000_0BAD);
    step();
    bus.core_result_valid = '0;
    check("spur_err", 64'(bus.err_spurious), 64'd1);
    check("spur_busy", 64'(bus.busy_count), 64'd3);
    repeat (3) step();
    check("spur_err_sticky", 64'(bus.err_spurious), 64'd1);
    check("spur_no_out", 64'(bus.out_valid), 64'd0);

    // 6: reset with busy cores, a buffered result and a held output word.
    send(32'h400, 1'b0, '0, 5);
    send(32'h401, 1'b0, '0, 1);
    send(32'h402, 1'b0, '0, 2);
    bus.out_ready = 1'b0;
    strobe(6, 32'hC6);
    strobe(7, 32'hC7);
    step();
    bus.core_result_valid = '0;
    step();
    check("pre_rst_busy", 64'(bus.busy_count), 64'd5);
    check("pre_rst_tag", 64'(bus.out_tag), 64'd6);
    reset = 1'b1;
    strobe(3, 32'hEE);
    step();
    reset = 1'b0;
    bus.core_result_valid = '0;
    #1;
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_busy", 64'(bus.busy_count), 64'd0);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_out_data", 64'(bus.out_data), 64'd0);
    check("mid_rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("mid_rst_err", 64'(bus.err_spurious), 64'd0);
    check("mid_rst_core_data", 64'(|bus.core_data), 64'd0);
    bus.out_ready = 1'b1;
    repeat (4) step();
    check("discarded_result", 64'(bus.out_valid), 64'd0);

    for (int i = 0; i < 20 && (disp_q.size() != 0 || out_q.size() != 0); i++)
      step();
    check("disp_queue_empty", 64'(disp_q.size()), 64'd0);
    check("out_queue_empty", 64'(out_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
